// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared types and screen-size defaults for the pixel plot
//               queue. pixel_t is the 18-bit queued pixel, q_state_t the
//               completion state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } q_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous show-ahead FIFO of pixel_t. The head entry is
//               visible on 'head' whenever the FIFO is not empty and reads
//               as zero when empty.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write strobe and data (ignored when full)
//               pop             - read strobe (ignored when empty)
//               full, empty     - occupancy flags
//               head            - current head entry
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  pixel_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output pixel_t head
);

    localparam int               c_aw      = $clog2(DEPTH);
    localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1);
    localparam logic [c_aw:0]    c_cnt_one = (c_aw+1)'(1);
    localparam logic [c_aw:0]    c_cnt_max = (c_aw+1)'(DEPTH);

    pixel_t            r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    logic w_push_en;
    logic w_pop_en;

    assign full      = (r_count == c_cnt_max);
    assign empty     = (r_count == '0);
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;

    // Head is forced to zero when empty so the outputs are defined after
    // reset without having to clear the storage array.
    assign head = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_plot_queue.sv
`default_nettype none
// ============================================================================
// Module      : pixel_plot_queue
// Description : Clips drawer pixel strobes to the visible screen, buffers the
//               survivors in a show-ahead FIFO and hands them to the VGA
//               adapter over valid/ready. Reports completion once the drawer
//               is done and every queued pixel has been written.
// Ports       : in_x/in_y/in_colour/in_plot/in_ready - drawer side
//               src_done                             - drawer done level
//               vga_x/vga_y/vga_colour/vga_plot/vga_ready - adapter side
//               drained       - done seen and queue empty
//               clipped_count - saturating count of clipped beats
//               overflow      - sticky, strobe seen while not ready
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_plot_queue
    import pixel_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    input  logic        src_done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    input  logic        vga_ready,
    output logic        drained,
    output logic [15:0] clipped_count,
    output logic        overflow
);

    localparam logic [1:0] c_st_run   = RUN;
    localparam logic [1:0] c_st_drain = DRAIN;
    localparam logic [1:0] c_st_done  = DONE;

    // One extra bit so a screen edge of 256/128 still compares correctly.
    localparam logic [8:0] c_x_lim = 9'(SCREEN_W);
    localparam logic [7:0] c_y_lim = 8'(SCREEN_H);

    logic   w_full;
    logic   w_empty;
    logic   w_accept;
    logic   w_clip;
    logic   w_push;
    logic   w_pop;
    pixel_t w_in_pix;
    pixel_t w_head;

    logic [1:0]  r_state;
    logic [15:0] r_clipped;
    logic        r_overflow;

    assign in_ready = !w_full;
    assign w_accept = in_plot && !w_full;
    assign w_clip   = ({1'b0, in_x} >= c_x_lim) || ({1'b0, in_y} >= c_y_lim);
    assign w_push   = w_accept && !w_clip;
    assign w_pop    = !w_empty && vga_ready;

    assign w_in_pix.x      = in_x;
    assign w_in_pix.y      = in_y;
    assign w_in_pix.colour = in_colour;

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_in_pix),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign vga_x         = w_head.x;
    assign vga_y         = w_head.y;
    assign vga_colour    = w_head.colour;
    assign vga_plot      = !w_empty;
    assign drained       = (r_state == c_st_done);
    assign clipped_count = r_clipped;
    assign overflow      = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clipped  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept && w_clip && (r_clipped != 16'hFFFF)) begin
                r_clipped <= r_clipped + 16'd1;
            end
            // A strobe against a full queue is lost, never counted as clipped.
            if (in_plot && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Completion tracking. A falling src_done always wins and returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (src_done) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (!src_done) begin
                        r_state <= c_st_run;
                    end else if (w_empty && !w_push) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (!src_done) begin
                        r_state <= c_st_run;
                    end else if (w_push) begin
                        r_state <= c_st_drain;
                    end
                end
                default: r_state <= c_st_run;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_plot_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_plot_queue
// Description : Self-checking bench for pixel_plot_queue. A negedge monitor
//               keeps a scoreboard queue of expected pixels plus reference
//               counters and completion state; directed sequences cover
//               single pixel, clipping, backpressure, drain, reset and
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_plot_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic        src_done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        vga_ready;
    logic        drained;
    logic [15:0] clipped_count;
    logic        overflow;

    pixel_plot_queue #(
        .DEPTH    (DEPTH),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .in_plot       (in_plot),
        .in_ready      (in_ready),
        .src_done      (src_done),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .vga_ready     (vga_ready),
        .drained       (drained),
        .clipped_count (clipped_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [17:0] sb[$];
    logic [15:0] m_clip;
    logic        m_ovf;
    int          m_st;      // 0 RUN, 1 DRAIN, 2 DONE
    logic        mon_en;
    int          m_occ;
    logic        m_acc;
    logic        m_clipb;
    logic        m_push;

    always @(negedge clk) begin
        if (mon_en) begin
            m_occ = sb.size();
            check("in_ready", in_ready, m_occ < DEPTH);
            check("vga_plot", vga_plot, m_occ != 0);
            if (m_occ != 0) begin
                check("head", {vga_x, vga_y, vga_colour}, sb[0]);
            end
            check("clipped_count", clipped_count, m_clip);
            check("overflow", overflow, m_ovf);
            check("drained", drained, m_st == 2);
            if (rst) begin
                sb.delete();
                m_clip = '0;
                m_ovf  = 1'b0;
                m_st   = 0;
            end else begin
                m_acc   = in_plot && (m_occ < DEPTH);
                m_clipb = (in_x >= 8'd160) || (in_y >= 7'd120);
                m_push  = m_acc && !m_clipb;
                if (in_plot && m_occ >= DEPTH) m_ovf = 1'b1;
                if (m_acc && m_clipb && m_clip != 16'hFFFF) m_clip = m_clip + 16'd1;
                case (m_st)
                    0: if (src_done) m_st = 1;
                    1: if (!src_done) m_st = 0; else if (m_occ == 0 && !m_push) m_st = 2;
                    default: if (!src_done) m_st = 0; else if (m_push) m_st = 1;
                endcase
                if (m_occ != 0 && vga_ready) begin
                    void'(sb.pop_front());
                    n_xfer++;
                end
                if (m_push) sb.push_back({in_x, in_y, in_colour});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        tick();
        in_x      = x;
        in_y      = y;
        in_colour = c;
        in_plot   = 1'b1;
    endtask

    task automatic idle();
        tick();
        in_plot = 1'b0;
    endtask

    int xfer_mark;
    int waited;

    initial begin
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        in_plot   = 1'b0;
        src_done  = 1'b0;
        vga_ready = 1'b1;
        sb.delete();
        m_clip    = '0;
        m_ovf     = 1'b0;
        m_st      = 0;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_vga_data", {vga_x, vga_y, vga_colour}, 0);
        check("rst_drained", drained, 0);
        check("rst_clipped", clipped_count, 0);
        check("rst_overflow", overflow, 0);

        // Single pixel, one cycle of latency
        plot(8'd40, 7'd30, 3'b101);
        idle();
        check("single_plot", vga_plot, 1);
        check("single_data", {vga_x, vga_y, vga_colour}, {8'd40, 7'd30, 3'd5});
        tick();
        check("single_gone", vga_plot, 0);
        check("single_clip", clipped_count, 0);

        // Clipping boundaries
        plot(8'd160, 7'd10, 3'd1);
        plot(8'd10, 7'd120, 3'd2);
        plot(8'd255, 7'd127, 3'd3);
        plot(8'd159, 7'd119, 3'd4);
        idle();
        tick();
        tick();
        check("clip_count", clipped_count, 3);

        // Backpressure and full
        xfer_mark = n_xfer;
        vga_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            plot(8'(i + 1), 7'(i + 50), 3'(i));
            if (i == 8) check("full_in_ready", in_ready, 0);
        end
        idle();
        check("full_overflow", overflow, 1);
        tick();
        tick();
        vga_ready = 1'b1;
        waited = 0;
        while (vga_plot && waited < 20) begin
            tick();
            waited++;
        end
        check("full_empty_timeout", vga_plot, 0);
        check("full_xfer_count", n_xfer - xfer_mark, 8);

        // Drain with toggling ready
        vga_ready = 1'b0;
        src_done  = 1'b1;
        for (int i = 0; i < 4; i++) plot(8'(i + 100), 7'(i + 5), 3'(7 - i));
        idle();
        for (int k = 0; k < 40; k++) begin
            if (!vga_plot) break;
            check("drain_early", drained, 0);
            vga_ready = ~vga_ready;
            tick();
        end
        check("drain_empty_timeout", vga_plot, 0);
        waited = 0;
        while (!drained && waited < 2) begin
            tick();
            waited++;
        end
        check("drain_late", drained, 1);
        src_done = 1'b0;
        tick();
        check("drain_clear", drained, 0);

        // Empty draw reaches DONE after two edges
        vga_ready = 1'b1;
        src_done  = 1'b1;
        tick();
        check("empty_draw_1", drained, 0);
        tick();
        check("empty_draw_2", drained, 1);
        src_done = 1'b0;
        tick();

        // Reset mid-stream flushes the queue
        vga_ready = 1'b0;
        for (int i = 0; i < 5; i++) plot(8'(i + 20), 7'(i + 60), 3'(i + 1));
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_plot", vga_plot, 0);
        check("midrst_clip", clipped_count, 0);
        check("midrst_ovf", overflow, 0);
        xfer_mark = n_xfer;
        vga_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("midrst_no_xfer", n_xfer - xfer_mark, 0);

        // Saturation of the clipped counter
        in_x      = 8'd200;
        in_y      = 7'd5;
        in_colour = 3'd1;
        in_plot   = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        in_plot = 1'b0;
        tick();
        check("sat_count", clipped_count, 16'hFFFF);
        check("sat_plot", vga_plot, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_plot_queue.md
# pixel_plot_queue

Buffers and clips the pixel-plot stream produced by the shape drawers (circle, Reuleaux, fill) before it reaches the VGA adapter. Each plot strobe carries a coordinate and colour. The block drops pixels outside the 160×120 screen, queues the rest in a small FIFO, and presents them to the adapter with a valid/ready handshake. It also reports completion only after the drawer has signalled done and every queued pixel has been written.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- SCREEN_W, 160, visible width; x ≥ SCREEN_W is clipped
- SCREEN_H, 120, visible height; y ≥ SCREEN_H is clipped

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_x  in  8  drawer pixel x
- in_y  in  7  drawer pixel y
- in_colour  in  3  drawer pixel colour
- in_plot  in  1  drawer strobe; beat accepted when in_plot && in_ready
- in_ready  out  1  queue not full
- src_done  in  1  drawer done level
- vga_x  out  8  head pixel x
- vga_y  out  7  head pixel y
- vga_colour  out  3  head pixel colour
- vga_plot  out  1  head valid
- vga_ready  in  1  adapter accepts; transfer when vga_plot && vga_ready
- drained  out  1  src_done seen and queue empty
- clipped_count  out  16  saturating count of clipped beats
- overflow  out  1  sticky; in_plot seen while in_ready=0

## Operation

- Accept rule: a beat is accepted when in_plot && in_ready.
- Clipping on accept:
  - in_x ≥ SCREEN_W or in_y ≥ SCREEN_H → beat discarded, clipped_count += 1.
  - clipped_count saturates at 16'hFFFF.
  - Otherwise {x,y,colour} is enqueued.
- in_ready = !full, combinational from the occupancy count.
  - When full, no beat is accepted, even if a dequeue happens in the same cycle.
  - Clipped beats also require in_ready=1.
- Overflow: in_plot=1 while in_ready=0 sets overflow, which stays high until rst. The beat is lost and is not counted as clipped.
- Output side is show-ahead:
  - vga_x/y/colour always show the FIFO head.
  - vga_plot = !empty.
  - While vga_plot && !vga_ready, all vga_* outputs hold stable.
- Ordering: strict FIFO; no reordering and no coalescing of duplicate pixels.
- Simultaneous enqueue and dequeue when not full and not empty: occupancy is unchanged and both operations take effect.
- State machine (drives drained):
  - RUN: reset state. Goes to DRAIN when src_done=1.
  - DRAIN: goes to DONE when the queue is empty and no enqueue occurs this cycle. Goes to RUN if src_done falls.
  - DONE: drained=1. An accepted unclipped beat returns the machine to DRAIN. src_done falling returns it to RUN.
- Empty-draw case: src_done while the queue is already empty reaches DONE via DRAIN in 2 cycles.

## Timing

- Reset values: in_ready=1, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, drained=0, clipped_count=0, overflow=0, state=RUN, FIFO pointers and occupancy=0.
- rst asserted mid-operation flushes all queued pixels on the next edge; no pending pixel is emitted afterwards.
- Latency: an unclipped beat accepted at edge N into an empty queue shows vga_plot=1 from edge N to edge N+1 (1 cycle).
- Throughput: 1 pixel/cycle sustained when vga_ready is held at 1.
- in_ready falls in the same cycle that occupancy reaches DEPTH.
- drained rises at most 2 edges after the last dequeue, provided src_done=1.
- All outputs are registered or derived only from registered state; there is no combinational path from in_* to vga_*.

## Structure

- Package pixel_pkg holds:
  - SCREEN_W and SCREEN_H localparam defaults.
  - typedef pixel_t: packed struct {x[7:0], y[6:0], colour[2:0]}, 18 bits.
  - typedef q_state_t enum {RUN, DRAIN, DONE}.
- Sub-module pixel_fifo: synchronous show-ahead FIFO of pixel_t.
  - Parameter DEPTH.
  - Ports: push, pop, full, empty, head.
- Top level contains the clip comparators, the counters, the overflow flag and the state machine.

## Test plan

- Single pixel: rst, then in_plot with (40,30,3'b101) and vga_ready=1 → next cycle vga_plot=1 with (40,30,5), then vga_plot=0. clipped_count=0.
- Clipping: drive x=160,y=10, then x=10,y=120, then x=255,y=127, then x=159,y=119 → only (159,119) emitted. clipped_count=3.
- Backpressure/full: vga_ready=0, plot 9 distinct pixels on consecutive cycles → in_ready=0 after the 8th. The 9th beat sets overflow. Raising vga_ready then emits exactly the 8 pixels in order, each held stable while stalled.
- Drain: src_done=1 with 4 pixels queued and vga_ready toggling 1/0 → drained stays 0 until all 4 are written, then drained=1 within 2 cycles. Dropping src_done then clears drained.
- Reset mid-stream: 5 pixels queued, pulse rst for 1 cycle → vga_plot=0 from the next edge, all counters cleared, and none of the 5 pixels ever appear.
- Saturation: feed 65,540 off-screen beats → clipped_count stops at 16'hFFFF and does not wrap.
